// File: rtl/wave_meas.sv
// wave_meas: bus-mapped wave capture peripheral. Samples a 32-bit wave every
// clock, times bit-0 edges (period, high time, rising-edge count) and tracks
// windowed min/max amplitude. Results are read back over the iomem bus.
module wave_meas #(
    parameter logic [31:0] DEF_WINDOW = 32'd16
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        sel,
    input  logic [3:0]  wstrb,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        ready,
    output logic [31:0] rdata,
    input  logic [31:0] wave_in
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ARM  = 2'd1,
        ST_MEAS = 2'd2
    } state_t;

    // Saturating increment; the top bit reports that the count was already full.
    function automatic logic [32:0] sat_inc(input logic [31:0] v);
        if (v == 32'hFFFF_FFFF) begin
            return {1'b1, v};
        end
        return {1'b0, v + 32'd1};
    endfunction

    state_t      state_q, state_d;
    logic        ready_q, ready_d;
    logic [31:0] rdata_q, rdata_d;
    logic        enable_q, enable_d;
    logic [31:0] window_q, window_d;
    logic [31:0] high_q, high_d;
    logic [31:0] period_q, period_d;
    logic [31:0] min_q, min_d;
    logic [31:0] max_q, max_d;
    logic [31:0] edges_q, edges_d;
    logic [31:0] per_cnt_q, per_cnt_d;
    logic [31:0] hi_cnt_q, hi_cnt_d;
    logic        per_valid_q, per_valid_d;
    logic        win_done_q, win_done_d;
    logic        overflow_q, overflow_d;
    logic [31:0] acc_min_q, acc_min_d;
    logic [31:0] acc_max_q, acc_max_d;
    logic [31:0] win_cnt_q, win_cnt_d;
    logic [31:0] s_cur_q, s_cur_d;
    logic        s_prev_q, s_prev_d;

    logic        access, is_wr, is_rd, wr_ctrl, wr_win, clr;
    logic [2:0]  reg_idx;
    logic        rise, fall;
    logic [31:0] rd_val, ctrl_rd;
    logic [32:0] per_inc, hi_inc, edges_inc;
    logic        win_first;
    logic [31:0] win_min_n, win_max_n, win_cnt_n;
    logic        unused_addr;

    assign unused_addr = ^{addr[31:5], addr[1:0]};

    // A new access is taken only when the previous ready pulse has ended.
    assign access  = sel & ~ready_q;
    assign is_wr   = access & (|wstrb);
    assign is_rd   = access & ~(|wstrb);
    assign reg_idx = addr[4:2];
    assign wr_ctrl = is_wr && (reg_idx == 3'd0);
    assign wr_win  = is_wr && (reg_idx == 3'd1);
    assign clr     = wr_ctrl & wdata[1];

    assign rise = s_cur_q[0] & ~s_prev_q;
    assign fall = ~s_cur_q[0] & s_prev_q;

    assign per_inc   = sat_inc(per_cnt_q);
    assign hi_inc    = sat_inc(hi_cnt_q);
    assign edges_inc = sat_inc(edges_q);

    // The first sample of a window loads both accumulators.
    assign win_first = (win_cnt_q == 32'd0);
    assign win_min_n = (win_first || (s_cur_q < acc_min_q)) ? s_cur_q : acc_min_q;
    assign win_max_n = (win_first || (s_cur_q > acc_max_q)) ? s_cur_q : acc_max_q;
    assign win_cnt_n = win_cnt_q + 32'd1;

    assign ctrl_rd = {25'd0, state_q, overflow_q, win_done_q, per_valid_q, 1'b0, enable_q};

    // Register read multiplexer, sampled from current register state.
    always_comb begin
        rd_val = 32'd0;
        case (reg_idx)
            3'd0:    rd_val = ctrl_rd;
            3'd1:    rd_val = window_q;
            3'd2:    rd_val = high_q;
            3'd3:    rd_val = period_q;
            3'd4:    rd_val = min_q;
            3'd5:    rd_val = max_q;
            3'd6:    rd_val = edges_q;
            default: rd_val = 32'd0;
        endcase
    end

    // Next-state logic: bus access, edge timing FSM, min/max window, clear.
    always_comb begin
        state_d     = state_q;
        enable_d    = enable_q;
        window_d    = window_q;
        high_d      = high_q;
        period_d    = period_q;
        min_d       = min_q;
        max_d       = max_q;
        edges_d     = edges_q;
        per_cnt_d   = per_cnt_q;
        hi_cnt_d    = hi_cnt_q;
        per_valid_d = per_valid_q;
        win_done_d  = win_done_q;
        overflow_d  = overflow_q;
        acc_min_d   = acc_min_q;
        acc_max_d   = acc_max_q;
        win_cnt_d   = win_cnt_q;
        s_cur_d     = wave_in;
        s_prev_d    = s_cur_q[0];

        ready_d = access;
        rdata_d = is_rd ? rd_val : 32'd0;

        if (wr_ctrl) begin
            enable_d = wdata[0];
        end
        if (wr_win) begin
            window_d = (wdata == 32'd0) ? 32'd1 : wdata;
        end

        // Read-to-clear goes first so that a same-cycle set wins.
        if (is_rd && (reg_idx == 3'd3)) begin
            per_valid_d = 1'b0;
        end
        if (is_rd && (reg_idx == 3'd5)) begin
            win_done_d = 1'b0;
        end

        // Using the post-write enable means a disabling write masks a coincident rise.
        if (enable_d) begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_ARM;
                end
                ST_ARM: begin
                    if (rise) begin
                        state_d    = ST_MEAS;
                        per_cnt_d  = 32'd1;
                        hi_cnt_d   = 32'd1;
                        edges_d    = edges_inc[31:0];
                        overflow_d = overflow_q | edges_inc[32];
                    end
                end
                ST_MEAS: begin
                    if (rise) begin
                        period_d    = per_cnt_q;
                        per_valid_d = 1'b1;
                        per_cnt_d   = 32'd1;
                        hi_cnt_d    = 32'd1;
                        edges_d     = edges_inc[31:0];
                        overflow_d  = overflow_q | edges_inc[32];
                    end else begin
                        per_cnt_d  = per_inc[31:0];
                        overflow_d = overflow_q | per_inc[32];
                        if (s_cur_q[0]) begin
                            hi_cnt_d   = hi_inc[31:0];
                            overflow_d = overflow_q | per_inc[32] | hi_inc[32];
                        end
                        if (fall) begin
                            high_d = hi_cnt_q;
                        end
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase

            if (state_q != ST_IDLE) begin
                if (win_cnt_n >= window_q) begin
                    min_d      = win_min_n;
                    max_d      = win_max_n;
                    win_done_d = 1'b1;
                    win_cnt_d  = 32'd0;
                end else begin
                    win_cnt_d  = win_cnt_n;
                end
                acc_min_d = win_min_n;
                acc_max_d = win_max_n;
            end
        end else begin
            state_d = ST_IDLE;
        end

        // Rewriting WINDOW discards the partial window.
        if (wr_win) begin
            win_cnt_d = 32'd0;
        end

        if (clr) begin
            per_cnt_d   = 32'd0;
            hi_cnt_d    = 32'd0;
            edges_d     = 32'd0;
            high_d      = 32'd0;
            period_d    = 32'd0;
            min_d       = 32'd0;
            max_d       = 32'd0;
            acc_min_d   = 32'd0;
            acc_max_d   = 32'd0;
            win_cnt_d   = 32'd0;
            per_valid_d = 1'b0;
            win_done_d  = 1'b0;
            overflow_d  = 1'b0;
            state_d     = enable_d ? ST_ARM : ST_IDLE;
        end
    end

    // State register including the FSM; everything returns to its reset value on resetn low.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= ST_IDLE;
            ready_q     <= 1'b0;
            rdata_q     <= 32'd0;
            enable_q    <= 1'b0;
            window_q    <= DEF_WINDOW;
            high_q      <= 32'd0;
            period_q    <= 32'd0;
            min_q       <= 32'd0;
            max_q       <= 32'd0;
            edges_q     <= 32'd0;
            per_cnt_q   <= 32'd0;
            hi_cnt_q    <= 32'd0;
            per_valid_q <= 1'b0;
            win_done_q  <= 1'b0;
            overflow_q  <= 1'b0;
            acc_min_q   <= 32'd0;
            acc_max_q   <= 32'd0;
            win_cnt_q   <= 32'd0;
            s_cur_q     <= 32'd0;
            s_prev_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            ready_q     <= ready_d;
            rdata_q     <= rdata_d;
            enable_q    <= enable_d;
            window_q    <= window_d;
            high_q      <= high_d;
            period_q    <= period_d;
            min_q       <= min_d;
            max_q       <= max_d;
            edges_q     <= edges_d;
            per_cnt_q   <= per_cnt_d;
            hi_cnt_q    <= hi_cnt_d;
            per_valid_q <= per_valid_d;
            win_done_q  <= win_done_d;
            overflow_q  <= overflow_d;
            acc_min_q   <= acc_min_d;
            acc_max_q   <= acc_max_d;
            win_cnt_q   <= win_cnt_d;
            s_cur_q     <= s_cur_d;
            s_prev_q    <= s_prev_d;
        end
    end

    assign ready = ready_q;
    assign rdata = rdata_q;

endmodule

// File: tb/tb_wave_meas.sv
// Bench for wave_meas: bus reads/writes, edge timing on square waves,
// windowed min/max, counter saturation and bus handshake behaviour.
module tb_wave_meas;

    logic        clk = 1'b0;
    logic        resetn;
    logic        sel;
    logic [3:0]  wstrb;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        ready;
    logic [31:0] rdata;
    logic [31:0] wave_in;

    int checks = 0;
    int errors = 0;

    logic [31:0] samp[$];

    wave_meas #(.DEF_WINDOW(32'd16)) dut (
        .clk     (clk),
        .resetn  (resetn),
        .sel     (sel),
        .wstrb   (wstrb),
        .addr    (addr),
        .wdata   (wdata),
        .ready   (ready),
        .rdata   (rdata),
        .wave_in (wave_in)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        @(negedge clk);
        sel = 1'b1; addr = a; wdata = d; wstrb = s;
        @(negedge clk);
        sel = 1'b0; wstrb = 4'h0;
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
        @(negedge clk);
        sel = 1'b1; addr = a; wstrb = 4'h0;
        @(negedge clk);
        d = ready ? rdata : 32'hDEAD_BEEF;
        sel = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] v;
        checks++; if (ready !== 1'b0 || rdata !== 32'd0) begin errors++; $display("FAIL reset_outputs got ready=%b rdata=%h want 0/0", ready, rdata); end
        bus_read(32'h0, v);
        checks++; if (v !== 32'h0) begin errors++; $display("FAIL reset_ctrl got %h want %h", v, 32'h0); end
        bus_read(32'h4, v);
        checks++; if (v !== 32'd16) begin errors++; $display("FAIL reset_window got %h want %h", v, 32'd16); end
        // change WINDOW, then reset in the middle of a read of it
        bus_write(32'h4, 32'd77, 4'hF);
        @(negedge clk);
        sel = 1'b1; addr = 32'h4; wstrb = 4'h0;
        @(posedge clk); #1;
        checks++; if (ready !== 1'b1 || rdata !== 32'd77) begin errors++; $display("FAIL midreset_pre got ready=%b rdata=%h want 1/%h", ready, rdata, 32'd77); end
        resetn = 1'b0;
        #1;
        checks++; if (ready !== 1'b0 || rdata !== 32'd0) begin errors++; $display("FAIL midreset_drop got ready=%b rdata=%h want 0/0", ready, rdata); end
        sel = 1'b0;
        @(negedge clk); @(negedge clk);
        resetn = 1'b1;
        bus_read(32'h0, v);
        checks++; if (v !== 32'h0) begin errors++; $display("FAIL midreset_ctrl got %h want %h", v, 32'h0); end
        bus_read(32'h4, v);
        checks++; if (v !== 32'd16) begin errors++; $display("FAIL midreset_window got %h want %h", v, 32'd16); end
    endtask

    task automatic test_edge_timing();
        logic [31:0] v;
        int h, l, n;
        for (int t = 0; t < 4; t++) begin
            if (t == 0) begin h = 4; l = 4; n = 10; end
            else begin h = $urandom_range(1, 8); l = $urandom_range(1, 8); n = $urandom_range(2, 6); end
            wave_in = 32'd0;
            repeat (3) @(negedge clk);
            bus_write(32'h0, 32'h3, 4'hF);
            for (int r = 0; r < n; r++) begin
                wave_in = 32'd1 | ($urandom & 32'hFFFF_FFFE);
                repeat (h) @(negedge clk);
                wave_in = $urandom & 32'hFFFF_FFFE;
                repeat (l) @(negedge clk);
            end
            wave_in = 32'd0;
            repeat (4) @(negedge clk);
            bus_read(32'h0, v);
            checks++; if ((v & 32'h77) !== (32'h1 | 32'h4 | (32'd2 << 5))) begin errors++; $display("FAIL edge_ctrl[%0d] got %h want %h", t, v & 32'h77, 32'h45); end
            bus_read(32'h8, v);
            checks++; if (v !== 32'(h)) begin errors++; $display("FAIL edge_high[%0d] got %0d want %0d", t, v, h); end
            bus_read(32'h18, v);
            checks++; if (v !== 32'(n)) begin errors++; $display("FAIL edge_count[%0d] got %0d want %0d", t, v, n); end
            bus_read(32'hC, v);
            checks++; if (v !== 32'(h + l)) begin errors++; $display("FAIL edge_period[%0d] got %0d want %0d", t, v, h + l); end
            bus_read(32'h0, v);
            checks++; if (v[2] !== 1'b0) begin errors++; $display("FAIL edge_perclr[%0d] got %b want 0", t, v[2]); end
        end
    endtask

    // Streams samp[] so that the window restarts right before samp[0] and
    // sampling stops right after the last entry.
    task automatic run_window(input logic [31:0] wv, input int n);
        bus_write(32'h0, 32'h1, 4'hF);
        wave_in = samp[0];
        bus_write(32'h4, wv, 4'hF);
        for (int i = 1; i < n; i++) begin
            wave_in = samp[i];
            @(negedge clk);
        end
        bus_write(32'h0, 32'h0, 4'hF);
    endtask

    task automatic test_window();
        logic [31:0] v, emin, emax, wv;
        int w, n;
        for (int t = 0; t < 6; t++) begin
            samp.delete();
            if (t == 0) begin wv = 4; samp = '{32'd5, 32'd9, 32'd2, 32'd7}; end
            else if (t == 1) begin wv = 4; samp = '{32'd1, 32'd1, 32'd1, 32'd1}; end
            else if (t == 2) begin wv = 0; samp = '{32'd300, 32'd12, 32'hABCD_0001}; end
            else begin
                wv = $urandom_range(1, 6);
                n = int'(wv) * $urandom_range(1, 3);
                for (int i = 0; i < n; i++) samp.push_back($urandom);
            end
            n = samp.size();
            w = (wv == 0) ? 1 : int'(wv);
            emin = 32'hFFFF_FFFF; emax = 32'd0;
            for (int i = n - w; i < n; i++) begin
                if (samp[i] < emin) emin = samp[i];
                if (samp[i] > emax) emax = samp[i];
            end
            run_window(wv, n);
            bus_read(32'h4, v);
            checks++; if (v !== 32'(w)) begin errors++; $display("FAIL win_reg[%0d] got %0d want %0d", t, v, w); end
            bus_read(32'h10, v);
            checks++; if (v !== emin) begin errors++; $display("FAIL win_min[%0d] got %h want %h", t, v, emin); end
            bus_read(32'h0, v);
            checks++; if (v[3] !== 1'b1) begin errors++; $display("FAIL win_done[%0d] got %b want 1", t, v[3]); end
            bus_read(32'h14, v);
            checks++; if (v !== emax) begin errors++; $display("FAIL win_max[%0d] got %h want %h", t, v, emax); end
            bus_read(32'h0, v);
            checks++; if (v[3] !== 1'b0) begin errors++; $display("FAIL win_doneclr[%0d] got %b want 0", t, v[3]); end
        end
    endtask

    task automatic test_saturation();
        logic [31:0] v;
        wave_in = 32'd0;
        repeat (3) @(negedge clk);
        bus_write(32'h4, 32'd1000, 4'hF);
        bus_write(32'h0, 32'h3, 4'hF);
        wave_in = 32'd1;
        repeat (4) @(negedge clk);
        force dut.per_cnt_q = 32'hFFFF_FFF0;
        force dut.hi_cnt_q  = 32'hFFFF_FFF0;
        @(posedge clk); #1;
        release dut.per_cnt_q;
        release dut.hi_cnt_q;
        repeat (30) @(negedge clk);
        bus_read(32'h0, v);
        checks++; if ((v & 32'h77) !== 32'h51) begin errors++; $display("FAIL sat_ctrl got %h want %h", v & 32'h77, 32'h51); end
        wave_in = 32'd0;
        repeat (3) @(negedge clk);
        wave_in = 32'd1;
        repeat (4) @(negedge clk);
        bus_read(32'h8, v);
        checks++; if (v !== 32'hFFFF_FFFF) begin errors++; $display("FAIL sat_high got %h want %h", v, 32'hFFFF_FFFF); end
        bus_read(32'hC, v);
        checks++; if (v !== 32'hFFFF_FFFF) begin errors++; $display("FAIL sat_period got %h want %h", v, 32'hFFFF_FFFF); end
        bus_read(32'h18, v);
        checks++; if (v !== 32'd2) begin errors++; $display("FAIL sat_edges got %0d want 2", v); end
        wave_in = 32'd0;
        repeat (3) @(negedge clk);
        bus_write(32'h0, 32'h3, 4'hF);
        bus_read(32'h0, v);
        checks++; if (v !== 32'h21) begin errors++; $display("FAIL clr_ctrl got %h want %h", v, 32'h21); end
        for (int a = 2; a <= 6; a++) begin
            bus_read(32'(a * 4), v);
            checks++; if (v !== 32'd0) begin errors++; $display("FAIL clr_reg%0d got %h want 0", a, v); end
        end
    endtask

    task automatic test_bus();
        logic [31:0] v, h0, d;
        int cnt, len;
        @(negedge clk);
        checks++; if (ready !== 1'b0 || rdata !== 32'd0) begin errors++; $display("FAIL bus_idle got ready=%b rdata=%h want 0/0", ready, rdata); end
        bus_write(32'h1C, $urandom, 4'hF);
        for (int t = 0; t < 4; t++) begin
            len = (t == 0) ? 3 : $urandom_range(1, 6);
            cnt = 0;
            @(negedge clk);
            sel = 1'b1; addr = 32'h1C; wstrb = 4'h0;
            for (int k = 0; k < len; k++) begin
                @(negedge clk);
                if (ready === 1'b1) begin
                    cnt++;
                    checks++; if (rdata !== 32'd0) begin errors++; $display("FAIL bus_addr7 got %h want 0", rdata); end
                end
            end
            sel = 1'b0;
            @(negedge clk);
            if (ready === 1'b1) cnt++;
            checks++; if (cnt !== (len + 1) / 2) begin errors++; $display("FAIL bus_pulses[len=%0d] got %0d want %0d", len, cnt, (len + 1) / 2); end
        end
        bus_read(32'h8, h0);
        bus_write(32'h8, h0 ^ 32'h5A5A_0F0F, 4'hF);
        bus_read(32'h8, v);
        checks++; if (v !== h0) begin errors++; $display("FAIL bus_ro_high got %h want %h", v, h0); end
        d = ($urandom & 32'h00FF_FFFF) | 32'h0100_0000;
        bus_write(32'h4, d, 4'b0001);
        bus_read(32'h4, v);
        checks++; if (v !== d) begin errors++; $display("FAIL bus_fullword got %h want %h", v, d); end
    endtask

    initial begin
        resetn  = 1'b0;
        sel     = 1'b0;
        wstrb   = 4'h0;
        addr    = 32'h0;
        wdata   = 32'h0;
        wave_in = 32'h0;
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        test_reset();
        test_edge_timing();
        test_window();
        test_saturation();
        test_bus();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
